// File: rtl/dec_2x4.sv
// 2-to-4 one-hot decoder with registered outputs.
// The select code is {a,b}. An optional input register stage adds one cycle
// of latency. When OUT_ACTIVE_LOW is set, y is inverted; valid is not.
// There is no combinational path from any input to y or valid.
module dec_2x4 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0,
    parameter bit IN_REG         = 1'b0
) (
    input  logic       SYSCLK,
    input  logic       SYSRESET,
    input  logic       a,
    input  logic       b,
    input  logic       en,
    output logic [3:0] y,
    output logic       valid
);

    // Value y takes while idle or in reset (nothing selected).
    localparam logic [3:0] Y_IDLE = OUT_ACTIVE_LOW ? 4'hF : 4'h0;

    // Inputs as seen by the decode stage (raw or registered).
    logic       a_s;
    logic       b_s;
    logic       en_s;
    logic [1:0] sel;
    logic [3:0] dec_next;
    logic [3:0] y_reg;
    logic       valid_reg;

    generate
        if (IN_REG) begin : g_in_reg
            logic a_reg;
            logic b_reg;
            logic en_reg;

            // Input stage: captures a, b, en; reset clears it so the first
            // decode after reset is a disabled one.
            always_ff @(posedge SYSCLK) begin
                if (SYSRESET) begin
                    a_reg  <= 1'b0;
                    b_reg  <= 1'b0;
                    en_reg <= 1'b0;
                end else begin
                    a_reg  <= a;
                    b_reg  <= b;
                    en_reg <= en;
                end
            end

            assign a_s  = a_reg;
            assign b_s  = b_reg;
            assign en_s = en_reg;
        end else begin : g_in_direct
            assign a_s  = a;
            assign b_s  = b;
            assign en_s = en;
        end
    endgenerate

    assign sel = {a_s, b_s};

    // One comparator per output bit. Each bit matches a distinct code, so at
    // most one bit of dec_next can be set.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign dec_next[gi] = en_s & (sel == 2'(gi));
        end
    endgenerate

    // Output stage: registered decode with optional inversion; reset wins.
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            y_reg     <= Y_IDLE;
            valid_reg <= 1'b0;
        end else begin
            y_reg     <= OUT_ACTIVE_LOW ? ~dec_next : dec_next;
            valid_reg <= en_s;
        end
    end

    assign y     = y_reg;
    assign valid = valid_reg;

endmodule

// File: tb/tb_dec_2x4.sv
// Bench for dec_2x4: a default instance (active-high, 1-cycle latency) and an
// inverted, input-registered instance (2-cycle latency) driven from the same
// stimulus. Expected results are queued when inputs are driven and popped
// after the edge at which the DUT should present them.
module tb_dec_2x4;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       en;
    logic [3:0] y0;
    logic       v0;
    logic [3:0] y1;
    logic       v1;

    int total;
    int bad;

    // Each queue entry holds {valid, y}.
    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic [4:0] last0;

    dec_2x4 #(.OUT_ACTIVE_LOW(1'b0), .IN_REG(1'b0)) dut0 (
        .SYSCLK(clk), .SYSRESET(rst), .a(a), .b(b), .en(en), .y(y0), .valid(v0)
    );

    dec_2x4 #(.OUT_ACTIVE_LOW(1'b1), .IN_REG(1'b1)) dut1 (
        .SYSCLK(clk), .SYSRESET(rst), .a(a), .b(b), .en(en), .y(y1), .valid(v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference one-hot decode for the active-high case.
    function automatic logic [3:0] onehot(input logic ia, input logic ib, input logic ien);
        logic [3:0] r;
        r = 4'h0;
        if (ien) r[{ia, ib}] = 1'b1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One transaction: drive inputs, queue expectations, clock, compare.
    task automatic step(input string tag, input logic ir, input logic ia,
                        input logic ib, input logic ien);
        logic [4:0] e0;
        logic [4:0] e1;
        rst = ir;
        a   = ia;
        b   = ib;
        en  = ien;
        q0.push_back(ir ? 5'b0_0000 : {ien, onehot(ia, ib, ien)});
        q1.push_back(ir ? 5'b0_1111 : {ien, ~onehot(ia, ib, ien)});
        @(posedge clk);
        #1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        // A reset edge also clears the input stage, so the next output of
        // the registered instance is the idle value rather than what was queued.
        if (ir) begin
            e1 = 5'b0_1111;
            q1.delete();
            q1.push_back(5'b0_1111);
        end
        check({tag, ".dut0"}, {v0, y0}, e0);
        check({tag, ".dut1"}, {v1, y1}, e1);
        check({tag, ".onehot0"}, {4'h0, ($countones(y0) <= 1)}, 5'b0_0001);
        check({tag, ".onehot1"}, {4'h0, ($countones(~y1) <= 1)}, 5'b0_0001);
        last0 = e0;
        $display("step %-10s rst=%b ab=%b%b en=%b | y0=%b v0=%b y1=%b v1=%b",
                 tag, ir, ia, ib, ien, y0, v0, y1, v1);
    endtask

    initial begin
        logic [4:0] e0;
        logic [4:0] e1;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        a     = 1'b0;
        b     = 1'b0;
        en    = 1'b0;
        // Registered instance needs one pending entry ahead of its first edge.
        q1.push_back(5'b0_1111);
        #1;

        // Reset held two edges with en=1, sel=11, then released.
        step("rst0", 1'b1, 1'b1, 1'b1, 1'b1);
        step("rst1", 1'b1, 1'b1, 1'b1, 1'b1);
        step("rel", 1'b0, 1'b1, 1'b1, 1'b1);
        step("rel2", 1'b0, 1'b1, 1'b1, 1'b1);

        // Disabled decode over all select codes.
        step("dis00", 1'b0, 1'b0, 1'b0, 1'b0);
        step("dis01", 1'b0, 1'b0, 1'b1, 1'b0);
        step("dis10", 1'b0, 1'b1, 1'b0, 1'b0);
        step("dis11", 1'b0, 1'b1, 1'b1, 1'b0);

        // Enabled sequence.
        step("seq00", 1'b0, 1'b0, 1'b0, 1'b1);
        step("seq10", 1'b0, 1'b1, 1'b0, 1'b1);
        step("seq11", 1'b0, 1'b1, 1'b1, 1'b1);
        step("seq01", 1'b0, 1'b0, 1'b1, 1'b1);
        step("seq00b", 1'b0, 1'b0, 1'b0, 1'b1);

        // Enable toggle with sel=10 held.
        step("en1", 1'b0, 1'b1, 1'b0, 1'b1);
        step("en0", 1'b0, 1'b1, 1'b0, 1'b0);
        step("en1b", 1'b0, 1'b1, 1'b0, 1'b1);

        // Glitching inputs between edges: outputs must hold until the edge,
        // and only the code stable at the edge (01) is decoded.
        en = 1'b1;
        a = 1'b1; b = 1'b0; #1;
        a = 1'b0; b = 1'b0; #1;
        a = 1'b1; b = 1'b1; #1;
        check("glitch.hold0", {v0, y0}, last0);
        a = 1'b0; b = 1'b1; #1;
        check("glitch.hold0b", {v0, y0}, last0);
        q0.push_back({1'b1, onehot(1'b0, 1'b1, 1'b1)});
        q1.push_back({1'b1, ~onehot(1'b0, 1'b1, 1'b1)});
        @(posedge clk);
        #1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check("glitch.dut0", {v0, y0}, e0);
        check("glitch.dut1", {v1, y1}, e1);
        $display("step %-10s ab=01 en=1 | y0=%b v0=%b y1=%b v1=%b", "glitch", y0, v0, y1, v1);

        // Inverted, registered instance: sel=11 appears two edges later.
        step("p_rst", 1'b1, 1'b1, 1'b1, 1'b1);
        step("p_11a", 1'b0, 1'b1, 1'b1, 1'b1);
        step("p_11b", 1'b0, 1'b1, 1'b1, 1'b1);
        check("p.y1_0111", {v1, y1}, 5'b1_0111);

        // Reset in the middle of traffic, then recovery.
        step("mid10", 1'b0, 1'b1, 1'b0, 1'b1);
        step("midrst", 1'b1, 1'b0, 1'b1, 1'b1);
        step("post01", 1'b0, 1'b0, 1'b1, 1'b1);
        step("post11", 1'b0, 1'b1, 1'b1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            step("rand", ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dec_2x4.md
DEC_2X4 -- requirements
Module: dec_2x4

Interface
REQ-001 Parameter OUT_ACTIVE_LOW, default 0: 0 = selected y bit driven 1 and others 0; 1 = all y bits inverted.
REQ-002 Parameter IN_REG, default 0: 0 = one input-to-output register stage; 1 = extra input register stage.
REQ-003 Port SYSCLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port SYSRESET  input  1  synchronous, active-high reset, sampled on the rising edge of SYSCLK.
REQ-005 Port a  input  1  select bit, MSB of the 2-bit select code.
REQ-006 Port b  input  1  select bit, LSB of the 2-bit select code.
REQ-007 Port en  input  1  decode enable, active-high.
REQ-008 Port y  output  4  registered one-hot decode result.
REQ-009 Port valid  output  1  registered; high when y reflects an enabled decode.
REQ-010 Port order SHALL be SYSCLK, SYSRESET, a, b, en, y, valid.

Function
REQ-011 Select code sel = {a,b}: a is bit 1, b is bit 0.
REQ-012 With en=1 (OUT_ACTIVE_LOW=0), next y SHALL be one-hot:
  - sel=00 -> y=0001
  - sel=01 -> y=0010
  - sel=10 -> y=0100
  - sel=11 -> y=1000
REQ-013 With en=0 (OUT_ACTIVE_LOW=0), next y SHALL be 0000 regardless of a and b.
REQ-014 next valid SHALL equal sampled en.
REQ-015 Latency with IN_REG=0: y and valid SHALL reflect the a, b, en values sampled at rising edge N, visible after edge N (1 cycle).
REQ-016 Latency with IN_REG=1: a, b, en SHALL first be registered, then decoded; total latency 2 cycles; both stages in lockstep.
REQ-017 OUT_ACTIVE_LOW=1 SHALL apply bitwise inversion of y only:
  - idle value 1111
  - sel=10 enabled -> 1011
  - valid unaffected.
REQ-018 y SHALL never have more than one asserted bit in any cycle, including cycles where inputs change between edges.
REQ-019 Input changes between clock edges SHALL have no effect on y or valid until the next rising edge (no combinational path from inputs to outputs).
REQ-020 Unknown (X/Z) on a, b or en when en is not 0 is a usage error; no defined output is required.

Reset
REQ-021 When SYSRESET=1 at a rising edge, the following SHALL be cleared, taking priority over all inputs:
  - valid=0
  - y=0000 (1111 when OUT_ACTIVE_LOW=1)
  - all input-stage registers when IN_REG=1
REQ-022 Reset asserted mid-operation SHALL take effect at the next rising edge.
REQ-023 The first edge after SYSRESET deasserts SHALL decode the inputs then present (IN_REG=0), or load the input stage (IN_REG=1).
REQ-024 Outputs before the first reset edge are undefined; no asynchronous behaviour is permitted.

Verification
REQ-025 Reset: SYSRESET=1 for 2 edges with en=1, a=1, b=1 -> y=0000, valid=0 throughout reset; after release, next edge gives y=1000, valid=1.
REQ-026 Disable: en=0 with all four (a,b) combinations over 4 cycles -> y=0000, valid=0 every cycle.
REQ-027 Sequence, one input set per cycle, en=1: (a,b) = 00, 10, 11, 01, 00 -> y one cycle later = 0001, 0100, 1000, 0010, 0001.
REQ-028 Enable toggle: en 1->0->1 with a=1, b=0 held -> y = 0100, 0000, 0100 and valid = 1, 0, 1, each one cycle after the input.
REQ-029 Glitch: a and b toggled twice between edges, stable 01 at the edge -> y=0010 only, no intermediate values.
REQ-030 Parameters: OUT_ACTIVE_LOW=1, IN_REG=1, en=1, (a,b)=11 -> y=0111 exactly two edges later; during reset y=1111.
